// File: rtl/multistage_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : multistage_synchronizer
// Brief    : Gray-pointer CDC synchronizer: STAGES-deep flop chain, registered
//            gray-to-binary, change strobe, optional gray integrity checker
//            (enabled by defining SYNC_GRAY_CHECK_EN).
// Revision : 1.0
// ============================================================================
module multistage_synchronizer #(
   parameter int             WIDTH   = 8,
   parameter int             STAGES  = 2,
   parameter logic [WIDTH:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH:0]   D_In,
   output logic [WIDTH:0]   D_Out,
   output logic [WIDTH:0]   Bin_Out,
   output logic             Changed,
   output logic             Gray_Err,
   output logic [7:0]       Err_Cnt
);

   function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
      logic [WIDTH:0] b;
      for (int i = 0; i <= WIDTH; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   localparam logic [WIDTH:0] c_rst_bin = gray2bin(RST_VAL);

   if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
      $error("multistage_synchronizer: STAGES must be in 2..4");
   end

   // r_sync[0] is the only flop that sees the asynchronous input.
   logic [STAGES-1:0][WIDTH:0] r_sync;
   logic [WIDTH:0]             r_prev;
   logic [WIDTH:0]             r_bin;
   logic                       r_changed;
   logic [WIDTH:0]             w_bin;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync <= {STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], D_In};
      end
   end

   assign D_Out = r_sync[STAGES-1];
   assign w_bin = gray2bin(D_Out);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_prev    <= RST_VAL;
         r_bin     <= c_rst_bin;
         r_changed <= 1'b0;
      end else begin
         r_prev    <= D_Out;
         r_bin     <= w_bin;
         r_changed <= (D_Out != r_prev);
      end
   end

   assign Bin_Out = r_bin;
   assign Changed = r_changed;

`ifdef SYNC_GRAY_CHECK_EN
   localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] w_diff;
   logic           w_multi;
   logic           r_gray_err;
   logic [7:0]     r_err_cnt;

   // More than one bit set <=> clearing the lowest set bit leaves something.
   assign w_diff  = D_Out ^ r_prev;
   assign w_multi = |(w_diff & (w_diff - c_one));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_gray_err <= 1'b0;
         r_err_cnt  <= 8'd0;
      end else begin
         r_gray_err <= w_multi;
         if (r_gray_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign Gray_Err = r_gray_err;
   assign Err_Cnt  = r_err_cnt;
`else
   assign Gray_Err = 1'b0;
   assign Err_Cnt  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multistage_synchronizer.sv
`default_nettype none
// Directed self-checking bench for multistage_synchronizer (STAGES 2, 3 and 4).
module tb_multistage_synchronizer;

`ifdef SYNC_GRAY_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       CLK  = 1'b0;
   logic       RST  = 1'b1;
   logic [8:0] D_In = 9'h000;

   logic [8:0] d_out2, bin2, d_out3, bin3, d_out4, bin4;
   logic       chg2, err2, chg3, err3, chg4, err4;
   logic [7:0] cnt2, cnt3, cnt4;

   int errors = 0;
   int checks = 0;

   multistage_synchronizer #(.WIDTH(8), .STAGES(2), .RST_VAL(9'h000)) u_dut2 (
      .CLK(CLK), .RST(RST), .D_In(D_In), .D_Out(d_out2), .Bin_Out(bin2),
      .Changed(chg2), .Gray_Err(err2), .Err_Cnt(cnt2));
   multistage_synchronizer #(.WIDTH(8), .STAGES(3), .RST_VAL(9'h000)) u_dut3 (
      .CLK(CLK), .RST(RST), .D_In(D_In), .D_Out(d_out3), .Bin_Out(bin3),
      .Changed(chg3), .Gray_Err(err3), .Err_Cnt(cnt3));
   multistage_synchronizer #(.WIDTH(8), .STAGES(4), .RST_VAL(9'h000)) u_dut4 (
      .CLK(CLK), .RST(RST), .D_In(D_In), .D_Out(d_out4), .Bin_Out(bin4),
      .Changed(chg4), .Gray_Err(err4), .Err_Cnt(cnt4));

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST  = 1'b1;
      D_In = 9'h000;
      tick();
      tick();
      RST = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      RST  = 1'b1;
      D_In = 9'h0AA;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({d_out2, bin2, chg2, err2, cnt2} !== 28'd0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: D_Out=%h Bin_Out=%h Changed=%b Gray_Err=%b Err_Cnt=%0d, required all 0",
                     k, d_out2, bin2, chg2, err2, cnt2);
         end
      end
      RST = 1'b0;
      tick();
      checks++;
      if (d_out2 !== 9'h000) begin
         errors++;
         $display("FAIL reset_release_e1: D_Out=%h required 000", d_out2);
      end
      tick();
      checks++;
      if (d_out2 !== 9'h0AA) begin
         errors++;
         $display("FAIL reset_release_e2: D_Out=%h required 0aa", d_out2);
      end
      tick();
      checks++;
      if (chg2 !== 1'b1 || bin2 !== 9'h0CC || err2 !== CHK) begin
         errors++;
         $display("FAIL reset_release_e3: Changed=%b Bin_Out=%h Gray_Err=%b, required 1 0cc %b",
                  chg2, bin2, err2, CHK);
      end
      tick();
      checks++;
      if (chg2 !== 1'b0 || err2 !== 1'b0 || cnt2 !== {7'd0, CHK}) begin
         errors++;
         $display("FAIL reset_release_e4: Changed=%b Gray_Err=%b Err_Cnt=%0d, required 0 0 %0d",
                  chg2, err2, cnt2, CHK);
      end
   endtask

   task automatic test_latency();
      do_reset();
      D_In = 9'h001;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (d_out2 !== ((k >= 2) ? 9'h001 : 9'h000) ||
             chg2   !== (k == 3) ||
             bin2   !== ((k >= 3) ? 9'h001 : 9'h000)) begin
            errors++;
            $display("FAIL latency_s2[e%0d]: D_Out=%h Changed=%b Bin_Out=%h", k, d_out2, chg2, bin2);
         end
         checks++;
         if (d_out3 !== ((k >= 3) ? 9'h001 : 9'h000) ||
             chg3   !== (k == 4) ||
             bin3   !== ((k >= 4) ? 9'h001 : 9'h000)) begin
            errors++;
            $display("FAIL latency_s3[e%0d]: D_Out=%h Changed=%b Bin_Out=%h", k, d_out3, chg3, bin3);
         end
         checks++;
         if (d_out4 !== ((k >= 4) ? 9'h001 : 9'h000) ||
             chg4   !== (k == 5) ||
             bin4   !== ((k >= 5) ? 9'h001 : 9'h000)) begin
            errors++;
            $display("FAIL latency_s4[e%0d]: D_Out=%h Changed=%b Bin_Out=%h", k, d_out4, chg4, bin4);
         end
      end
   endtask

   task automatic test_gray_count();
      int         pulses = 0;
      logic [8:0] b;
      do_reset();
      for (int n = 1; n <= 512; n++) begin
         b    = 9'(n % 512);
         D_In = b ^ (b >> 1);
         for (int t = 0; t < 4; t++) begin
            tick();
            if (chg2 === 1'b1) pulses++;
            checks++;
            if (err2 !== 1'b0) begin
               errors++;
               $display("FAIL gray_count_err[n=%0d]: Gray_Err=%b required 0", n, err2);
            end
         end
         checks++;
         if (bin2 !== b) begin
            errors++;
            $display("FAIL gray_count_bin[n=%0d]: Bin_Out=%0d required %0d", n, bin2, b);
         end
      end
      checks++;
      if (pulses != 512 || cnt2 !== 8'd0) begin
         errors++;
         $display("FAIL gray_count_totals: pulses=%0d Err_Cnt=%0d, required 512 0", pulses, cnt2);
      end
   endtask

   task automatic test_integrity();
      int err_pulses = 0;
      int chg_pulses = 0;
      do_reset();
      D_In = 9'h003;
      tick();
      tick();
      checks++;
      if (d_out2 !== 9'h003) begin
         errors++;
         $display("FAIL integrity_dout: D_Out=%h required 003", d_out2);
      end
      tick();
      checks++;
      if (chg2 !== 1'b1 || err2 !== CHK || bin2 !== 9'h002) begin
         errors++;
         $display("FAIL integrity_strobe: Changed=%b Gray_Err=%b Bin_Out=%h, required 1 %b 002",
                  chg2, err2, bin2, CHK);
      end
      tick();
      checks++;
      if (chg2 !== 1'b0 || err2 !== 1'b0 || cnt2 !== {7'd0, CHK}) begin
         errors++;
         $display("FAIL integrity_count: Changed=%b Gray_Err=%b Err_Cnt=%0d, required 0 0 %0d",
                  chg2, err2, cnt2, CHK);
      end
      for (int i = 0; i < 300; i++) begin
         D_In = (i % 2 == 1) ? 9'h003 : 9'h000;
         for (int t = 0; t < 2; t++) begin
            tick();
            if (err2 === 1'b1) err_pulses++;
            if (chg2 === 1'b1) chg_pulses++;
         end
      end
      for (int t = 0; t < 5; t++) begin
         tick();
         if (err2 === 1'b1) err_pulses++;
         if (chg2 === 1'b1) chg_pulses++;
      end
      checks++;
      if (err_pulses != (CHK ? 300 : 0) || chg_pulses != 300) begin
         errors++;
         $display("FAIL integrity_pulses: Gray_Err pulses=%0d Changed pulses=%0d, required %0d 300",
                  err_pulses, chg_pulses, CHK ? 300 : 0);
      end
      checks++;
      if (cnt2 !== (CHK ? 8'd255 : 8'd0) || bin2 !== 9'h002) begin
         errors++;
         $display("FAIL integrity_saturate: Err_Cnt=%0d Bin_Out=%h, required %0d 002",
                  cnt2, bin2, CHK ? 255 : 0);
      end
   endtask

   task automatic test_midflight_reset();
      logic [8:0] seq [5] = '{9'h003, 9'h000, 9'h003, 9'h006, 9'h000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         D_In = seq[i];
         tick();
         tick();
      end
      repeat (5) tick();
      checks++;
      if (cnt2 !== (CHK ? 8'd5 : 8'd0) || d_out2 !== 9'h000) begin
         errors++;
         $display("FAIL midflight_prior: Err_Cnt=%0d D_Out=%h, required %0d 000",
                  cnt2, d_out2, CHK ? 5 : 0);
      end
      D_In = 9'h001;
      tick();
      checks++;
      if (d_out2 !== 9'h000 || chg2 !== 1'b0) begin
         errors++;
         $display("FAIL midflight_e1: D_Out=%h Changed=%b, required 000 0", d_out2, chg2);
      end
      RST  = 1'b1;
      D_In = 9'h000;
      for (int t = 0; t < 2; t++) begin
         tick();
         checks++;
         if (d_out2 !== 9'h000 || chg2 !== 1'b0 || err2 !== 1'b0 || cnt2 !== 8'd0) begin
            errors++;
            $display("FAIL midflight_rst[%0d]: D_Out=%h Changed=%b Gray_Err=%b Err_Cnt=%0d, required 000 0 0 0",
                     t, d_out2, chg2, err2, cnt2);
         end
      end
      RST = 1'b0;
      for (int t = 0; t < 4; t++) begin
         tick();
         checks++;
         if (d_out2 !== 9'h000 || chg2 !== 1'b0) begin
            errors++;
            $display("FAIL midflight_after[%0d]: D_Out=%h Changed=%b, required 000 0", t, d_out2, chg2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_gray_count();
      test_integrity();
      test_midflight_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
